// File: rtl/feature_map_loader.sv
// feature_map_loader: accepts an 8-bit activation stream in C->W->H or
// W->H->C order and captures one selected channel into an 8x8 tile.
// The tile stays frozen and readable until the consumer acknowledges it.
module feature_map_loader #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 8,
    parameter int CNT_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [5:0]        cfg_width,
    input  logic [5:0]        cfg_height,
    input  logic [6:0]        cfg_channels,
    input  logic              cfg_order_cwh,
    input  logic [6:0]        cfg_channel_sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tile_valid,
    input  logic              tile_ack,
    input  logic [2:0]        rd_row,
    input  logic [2:0]        rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  beat_count
);

    localparam int         TILE_N    = MAX_DIM * MAX_DIM;
    localparam logic [5:0] MAX_DIM_W = 6'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t             state_q;
    logic               in_ready_q, busy_q, tile_valid_q, done_q, error_q;
    logic [CNT_W-1:0]   beat_q, total_q;
    logic [2:0]         wlast_q, hlast_q;
    logic [6:0]         clast_q, sel_q;
    logic               cwh_q;
    logic [6:0]         ch_q, ch_d;
    logic [2:0]         col_q, col_d, row_q, row_d;

    logic [DATA_W-1:0]  mem [TILE_N];
    logic [TILE_N-1:0]  valid_q;
    logic [TILE_N-1:0]  wr_hit;
    logic [DATA_W-1:0]  mem_rd_q;
    logic               rd_vld_q;

    logic               cfg_ok, accept_cfg, xfer, last_beat, wr_en;
    logic [5:0]         wr_idx, rd_idx;

    assign cfg_ok = (cfg_width  >= 6'd1) && (cfg_width  <= MAX_DIM_W) &&
                    (cfg_height >= 6'd1) && (cfg_height <= MAX_DIM_W) &&
                    (cfg_channels != 7'd0) && (cfg_channel_sel < cfg_channels);

    assign accept_cfg = (state_q == IDLE) && cfg_start && cfg_ok;
    // in_ready_q is high exactly while in LOAD, so it qualifies transfers
    assign xfer       = in_valid && in_ready_q;
    assign last_beat  = (beat_q + CNT_W'(1)) == total_q;
    assign wr_en      = xfer && (ch_q == sel_q);
    assign wr_idx     = {row_q, col_q};
    assign rd_idx     = {rd_row, rd_col};

    // Next position: innermost counter wraps and carries into the next one
    always_comb begin
        ch_d  = ch_q;
        col_d = col_q;
        row_d = row_q;
        if (cwh_q) begin
            if (ch_q == clast_q) begin
                ch_d = 7'd0;
                if (col_q == wlast_q) begin
                    col_d = 3'd0;
                    row_d = (row_q == hlast_q) ? 3'd0 : row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end else begin
                ch_d = ch_q + 7'd1;
            end
        end else begin
            if (col_q == wlast_q) begin
                col_d = 3'd0;
                if (row_q == hlast_q) begin
                    row_d = 3'd0;
                    ch_d  = ch_q + 7'd1;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    // Control FSM with registered handshake/status outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            tile_valid_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            beat_q       <= '0;
            total_q      <= '0;
            wlast_q      <= 3'd0;
            hlast_q      <= 3'd0;
            clast_q      <= 7'd0;
            sel_q        <= 7'd0;
            cwh_q        <= 1'b0;
            ch_q         <= 7'd0;
            col_q        <= 3'd0;
            row_q        <= 3'd0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_ok) begin
                            wlast_q    <= 3'(cfg_width - 6'd1);
                            hlast_q    <= 3'(cfg_height - 6'd1);
                            clast_q    <= cfg_channels - 7'd1;
                            sel_q      <= cfg_channel_sel;
                            cwh_q      <= cfg_order_cwh;
                            total_q    <= CNT_W'(cfg_width) * CNT_W'(cfg_height) *
                                          CNT_W'(cfg_channels);
                            beat_q     <= '0;
                            ch_q       <= 7'd0;
                            col_q      <= 3'd0;
                            row_q      <= 3'd0;
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        beat_q <= beat_q + CNT_W'(1);
                        ch_q   <= ch_d;
                        col_q  <= col_d;
                        row_q  <= row_d;
                        if (last_beat) begin
                            state_q      <= HOLD;
                            in_ready_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            tile_valid_q <= 1'b1;
                            done_q       <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tile_ack) begin
                        state_q      <= IDLE;
                        tile_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Per-entry write strobes for the valid bitmap
    generate
        for (genvar gi = 0; gi < TILE_N; gi++) begin : g_hit
            assign wr_hit[gi] = wr_en && (wr_idx == 6'(gi));
        end
    endgenerate

    // Valid bitmap: wiped by reset or a new accepted load, set on each write
    always_ff @(posedge clk) begin
        if (rst || accept_cfg) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_q | wr_hit;
        end
    end

    // Tile storage: plain array with registered read, no reset on the data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= in_data;
        end
        mem_rd_q <= mem[rd_idx];
    end

    // Registered copy of the addressed valid bit so unwritten entries read 0
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= valid_q[rd_idx];
        end
    end

    assign rd_data    = rd_vld_q ? mem_rd_q : '0;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign tile_valid = tile_valid_q;
    assign done       = done_q;
    assign error      = error_q;
    assign beat_count = beat_q;

endmodule

// File: tb/tb_feature_map_loader.sv
// Bench for feature_map_loader: vector table of configurations, hand-written
// corner sequences, and randomized loads checked against an index-arithmetic
// model of where each stream element lands in the tile.
module tb_feature_map_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [5:0]  cfg_width, cfg_height;
    logic [6:0]  cfg_channels, cfg_channel_sel;
    logic        cfg_order_cwh;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, tile_valid, tile_ack;
    logic [2:0]  rd_row, rd_col;
    logic [7:0]  rd_data;
    logic        busy, done, error;
    logic [12:0] beat_count;

    feature_map_loader dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_channels(cfg_channels), .cfg_order_cwh(cfg_order_cwh),
        .cfg_channel_sel(cfg_channel_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .tile_valid(tile_valid), .tile_ack(tile_ack),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .busy(busy), .done(done), .error(error), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w, h, c, sel, cwh;
        bit legal;      // expected: configuration accepted
        bit rnd;        // random data instead of base+k
        int base;
        int stall_pct;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   exp_tile [8][8];
    vec_t vecs [10];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp_tile[r][c] = 0;
    endtask

    task automatic start_cfg(int w, int h, int c, int sel, int cwh);
        cfg_width       = 6'(w);
        cfg_height      = 6'(h);
        cfg_channels    = 7'(c);
        cfg_channel_sel = 7'(sel);
        cfg_order_cwh   = 1'(cwh);
        cfg_start       = 1'b1;
        tick;
        cfg_start       = 1'b0;
    endtask

    // Stream up to n_stop beats; the model places beat k by pure arithmetic
    task automatic stream(int w, int h, int c, int sel, int cwh, int n_stop,
                          bit rnd, int base, int stall_pct);
        int total, k, cyc, ch, col, row;
        logic [7:0] d;
        bit acc;
        total = w * h * c;
        k = 0;
        cyc = 0;
        while (k < n_stop && cyc < n_stop * 30 + 100) begin
            in_valid = ($urandom_range(99) >= stall_pct);
            d = rnd ? 8'($urandom) : 8'(base + k);
            in_data = d;
            acc = in_valid && in_ready;
            if (acc) begin
                if (cwh != 0) begin
                    ch = k % c; col = (k / c) % w; row = k / (c * w);
                end else begin
                    col = k % w; row = (k / w) % h; ch = k / (w * h);
                end
                if (ch == sel) exp_tile[row][col] = d;
                k++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        chk("beats_accepted", k, n_stop);
        chk("beat_count", beat_count, k);
        if (n_stop == total) begin
            chk("done_pulse", done, 1);
            chk("tile_valid_rise", tile_valid, 1);
            chk("in_ready_after_last", in_ready, 0);
            chk("busy_after_last", busy, 0);
            in_valid = 1'b1;
            in_data  = 8'hEE;
            for (int i = 0; i < 3; i++) begin
                tick;
                chk("hold_in_ready", in_ready, 0);
                chk("hold_beat_count", beat_count, total);
                chk("done_single", done, 0);
                chk("hold_tile_valid", tile_valid, 1);
            end
            in_valid = 1'b0;
        end
        $display("load w=%0d h=%0d c=%0d sel=%0d cwh=%0d beats=%0d/%0d",
                 w, h, c, sel, cwh, k, total);
    endtask

    task automatic read_at(int r, int c, output int v);
        rd_row = 3'(r);
        rd_col = 3'(c);
        tick;
        v = rd_data;
    endtask

    task automatic check_tile(string tag);
        int v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                read_at(r, c, v);
                chk($sformatf("%s rd[%0d][%0d]", tag, r, c), v, exp_tile[r][c]);
            end
    endtask

    task automatic ack;
        tile_ack = 1'b1;
        tick;
        tile_ack = 1'b0;
        chk("ack_tile_valid", tile_valid, 0);
    endtask

    task automatic full_load(vec_t v);
        clear_model;
        start_cfg(v.w, v.h, v.c, v.sel, v.cwh);
        chk("load_busy", busy, 1);
        chk("load_in_ready", in_ready, 1);
        stream(v.w, v.h, v.c, v.sel, v.cwh, v.w * v.h * v.c, v.rnd, v.base, v.stall_pct);
    endtask

    initial begin
        int   v;
        vec_t rv;
        rst = 1'b1; cfg_start = 1'b0; cfg_width = 6'd0; cfg_height = 6'd0;
        cfg_channels = 7'd0; cfg_channel_sel = 7'd0; cfg_order_cwh = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; tile_ack = 1'b0;
        rd_row = 3'd0; rd_col = 3'd0;

        vecs[0] = '{w:4, h:3, c:1, sel:0, cwh:1, legal:1, rnd:0, base:1, stall_pct:0};
        vecs[1] = '{w:2, h:2, c:3, sel:2, cwh:1, legal:1, rnd:0, base:0, stall_pct:0};
        vecs[2] = '{w:2, h:2, c:3, sel:1, cwh:0, legal:1, rnd:0, base:0, stall_pct:0};
        vecs[3] = '{w:8, h:8, c:2, sel:1, cwh:1, legal:1, rnd:1, base:0, stall_pct:50};
        vecs[4] = '{w:0, h:3, c:1, sel:0, cwh:1, legal:0, rnd:0, base:0, stall_pct:0};
        vecs[5] = '{w:4, h:9, c:1, sel:0, cwh:1, legal:0, rnd:0, base:0, stall_pct:0};
        vecs[6] = '{w:4, h:4, c:5, sel:5, cwh:1, legal:0, rnd:0, base:0, stall_pct:0};
        vecs[7] = '{w:8, h:8, c:3, sel:0, cwh:0, legal:1, rnd:1, base:0, stall_pct:30};
        vecs[8] = '{w:1, h:1, c:1, sel:0, cwh:1, legal:1, rnd:1, base:0, stall_pct:0};
        vecs[9] = '{w:5, h:7, c:4, sel:3, cwh:0, legal:1, rnd:1, base:0, stall_pct:20};

        tick; tick;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_tile_valid", tile_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_beat_count", beat_count, 0);

        // Basic load, explicit expectations
        full_load(vecs[0]);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                read_at(r, c, v);
                chk($sformatf("basic rd[%0d][%0d]", r, c), v,
                    (r < 3 && c < 4) ? 4 * r + c + 1 : 0);
            end
        ack;

        // CWH channel select, explicit expectations
        full_load(vecs[1]);
        chk("cwh_beat_count", beat_count, 12);
        read_at(0, 0, v); chk("cwh [0][0]", v, 2);
        read_at(0, 1, v); chk("cwh [0][1]", v, 5);
        read_at(1, 0, v); chk("cwh [1][0]", v, 8);
        read_at(1, 1, v); chk("cwh [1][1]", v, 11);
        ack;

        // WHC order, explicit expectations
        full_load(vecs[2]);
        read_at(0, 0, v); chk("whc [0][0]", v, 4);
        read_at(0, 1, v); chk("whc [0][1]", v, 5);
        read_at(1, 0, v); chk("whc [1][0]", v, 6);
        read_at(1, 1, v); chk("whc [1][1]", v, 7);
        ack;

        // Table-driven pass against the model
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].legal) begin
                full_load(vecs[i]);
                check_tile($sformatf("vec%0d", i));
                ack;
            end else begin
                start_cfg(vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].sel, vecs[i].cwh);
                chk("illegal_error", error, 1);
                chk("illegal_busy", busy, 0);
                chk("illegal_in_ready", in_ready, 0);
                tick;
                chk("illegal_error_pulse", error, 0);
                chk("illegal_stay_idle", busy, 0);
                $display("config w=%0d h=%0d c=%0d sel=%0d rejected",
                         vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].sel);
            end
        end

        // Reset in the middle of a load
        clear_model;
        start_cfg(4, 4, 2, 0, 1);
        stream(4, 4, 2, 0, 1, 7, 1'b1, 0, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tile_valid", tile_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_beat_count", beat_count, 0);
        clear_model;
        check_tile("midrst");
        $display("reset at beat 7 applied");

        // Ack with a coincident cfg_start: the start must be dropped
        full_load('{w:3, h:3, c:1, sel:0, cwh:1, legal:1, rnd:1, base:0, stall_pct:0});
        cfg_width = 6'd2; cfg_height = 6'd2; cfg_channels = 7'd1;
        cfg_channel_sel = 7'd0; cfg_order_cwh = 1'b1;
        cfg_start = 1'b1;
        tile_ack  = 1'b1;
        tick;
        cfg_start = 1'b0;
        tile_ack  = 1'b0;
        chk("ackstart_tile_valid", tile_valid, 0);
        chk("ackstart_busy", busy, 0);
        chk("ackstart_error", error, 0);
        tick;
        chk("ackstart_still_idle", busy, 0);
        chk("ackstart_in_ready", in_ready, 0);
        check_tile("after_ack");
        $display("ack with coincident cfg_start applied");

        // Randomized legal loads
        for (int i = 0; i < 4; i++) begin
            rv.w = $urandom_range(8, 1);
            rv.h = $urandom_range(8, 1);
            rv.c = $urandom_range(6, 1);
            rv.sel = $urandom_range(rv.c - 1, 0);
            rv.cwh = $urandom_range(1, 0);
            rv.legal = 1'b1;
            rv.rnd = 1'b1;
            rv.base = 0;
            rv.stall_pct = $urandom_range(60, 0);
            full_load(rv);
            check_tile($sformatf("rand%0d", i));
            ack;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feature_map_loader.md
Name: feature_map_loader

Overview:
Upstream stage of the pooling preprocessing block. It accepts a raw 8-bit activation stream over a valid/ready handshake, in either C->W->H or W->H->C order. It extracts one selected channel into an internal 8x8 tile and presents that tile through a synchronous random-access read port. It holds the tile until the consumer acknowledges it, which gives the pooling stage a stable feature map to window over.

Parameters:
DATA_W, 8, width of each stream element and tile entry
MAX_DIM, 8, maximum tile width/height; tile storage is MAX_DIM x MAX_DIM
CNT_W, 13, width of the beat counter; must cover MAX_DIM*MAX_DIM*127

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse; latches cfg_* and starts a load (honoured only in IDLE)
cfg_width  in  6  feature map width, legal 1..MAX_DIM
cfg_height  in  6  feature map height, legal 1..MAX_DIM
cfg_channels  in  7  channel count, legal 1..127
cfg_order_cwh  in  1  1 = channel fastest, then column, then row; 0 = column fastest, then row, then channel
cfg_channel_sel  in  7  channel captured into tile, must be < cfg_channels
in_valid  in  1  stream element valid
in_data  in  DATA_W  stream element
in_ready  out  1  loader accepts element this cycle
tile_valid  out  1  tile complete and stable
tile_ack  in  1  consumer releases tile
rd_row  in  3  tile read row
rd_col  in  3  tile read column
rd_data  out  DATA_W  tile[rd_row][rd_col], registered
busy  out  1  high in LOAD
done  out  1  one-cycle pulse on LOAD->HOLD
error  out  1  one-cycle pulse on rejected configuration
beat_count  out  CNT_W  elements accepted in the current load

Behaviour:
- Reset values: in_ready=0, tile_valid=0, busy=0, done=0, error=0, rd_data=0, beat_count=0, state=IDLE. All 64 entry-valid bits are cleared.
- Reset during any state aborts the load. No partial tile is ever flagged valid.
- The FSM has three states: IDLE, LOAD and HOLD.
- IDLE behaviour:
  - in_ready=0.
  - On cfg_start, the loader checks the configuration: width in 1..8, height in 1..8, channels >= 1, and sel < channels.
  - Illegal configuration: error=1 for the next cycle and the FSM stays in IDLE.
  - Legal configuration: the loader latches cfg_*, clears all valid bits, zeros the counters, and enters LOAD on the next cycle.
- LOAD behaviour:
  - in_ready=1 and busy=1.
  - A beat transfers when in_valid & in_ready. Each transfer increments beat_count.
  - Position counters are ch, col and row.
  - CWH order: ch wraps at channels-1 and carries into col. col wraps at width-1 and carries into row.
  - Non-CWH order: col wraps at width-1 and carries into row. row wraps at height-1 and carries into ch.
  - When ch==sel, in_data is written to tile[row][col] and that entry's valid bit is set.
- LOAD->HOLD: on the transfer where beat_count reaches width*height*channels.
  - in_ready drops in the following cycle. No extra beat is ever accepted.
  - done pulses one cycle, coincident with tile_valid first rising.
- HOLD behaviour:
  - tile_valid=1, in_ready=0, and the tile is frozen.
  - tile_ack in HOLD returns the FSM to IDLE next cycle, with tile_valid=0.
  - tile_ack outside HOLD is ignored.
- cfg_start outside IDLE is ignored and raises no error.
- cfg_start coincident with tile_ack in HOLD is ignored; the consumer must re-issue it in IDLE.
- Read port:
  - rd_data is updated every cycle, with 1-cycle latency.
  - It returns the entry if its valid bit is set, else 0.
  - Entries outside width x height therefore read as 0.
  - Reads are legal in any state. During LOAD they return partially written contents.
- A stall (in_valid=0) in LOAD holds all counters. There is no timeout.
- Arithmetic: the expected-beat product is computed once at latch into CNT_W bits. It never overflows given the legal ranges.

Test Plan:
1. Basic load: width=4, height=3, channels=1, sel=0, cwh=1, data 1..12 back-to-back -> done after beat 12. tile[r][c]=4r+c+1 for r<3, c<4; all other entries read 0; in_ready=0 from the cycle after beat 12.
2. CWH channel select: width=2, height=2, channels=3, sel=2, data 0..11 -> tile[0][0]=2, [0][1]=5, [1][0]=8, [1][1]=11; beat_count=12.
3. WHC order: same dims with cwh=0, sel=1, data 0..11 -> tile[0][0]=4, [0][1]=5, [1][0]=6, [1][1]=7.
4. Backpressure and stalls: in_valid toggled randomly during an 8x8x2 load -> exactly 128 beats accepted; tile matches the reference model; no beat accepted while in HOLD even with in_valid held high.
5. Illegal configurations: width=0, then height=9, then sel=channels=5 -> error one-cycle pulse each time; state stays IDLE; in_ready=0; busy=0.
6. Reset and ack: rst asserted mid-LOAD at beat 7 -> all outputs reach reset values next cycle and all reads return 0. A separate full load with tile_ack held for 1 cycle -> tile_valid falls next cycle; a cfg_start in that same cycle is ignored.
